hilo_muldiv: RTL and testbench



---
 rtl/hilo_muldiv.sv | 155 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiply/divide engine.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining HILO_MACC_EN.
module hilo_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] hi_wdata,
   input  logic [WIDTH-1:0] lo_wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_data,
   output logic [WIDTH-1:0] lo_data
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             accept, legal, busy_nxt, done_nxt;
   logic             is_div_q, neg_a_q, neg_b_q;
   logic [WIDTH-1:0] opnd, acc_hi, acc_lo;

   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [PW-1:0]    prod, prod_s, mac_res;
   logic [WIDTH-1:0] quot, rem, res_hi, res_lo;

`ifdef HILO_MACC_EN
   logic             is_mac_q, is_sub_q;
   logic [PW-1:0]    base_q;
   assign legal = 1'b1;
`else
   assign legal = ~op[2];
`endif

   // Operand magnitudes; op[0]=1 selects the unsigned variant.
   always_comb begin
      neg_a = ~op[0] & src_a[WIDTH-1];
      neg_b = ~op[0] & src_b[WIDTH-1];
      mag_a = neg_a ? -src_a : src_a;
      mag_b = neg_b ? -src_b : src_b;
   end

   // Next state and registered-output values.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !cancel && legal) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cancel)                         state_nxt = IDLE;
            else if (cnt == CW'(WIDTH - 1))     state_nxt = FIN;
         end
         FIN: begin
            state_nxt = IDLE;
            done_nxt  = !cancel;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // One iteration: shift-add multiply (acc_hi:acc_lo shifts right) or restoring divide.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (WIDTH + 1)'(0));
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
   end

   // Sign fix-up and final HI/LO result.
   always_comb begin
      prod    = {acc_hi, acc_lo};
      prod_s  = (neg_a_q ^ neg_b_q) ? -prod : prod;
      quot    = (opnd == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -acc_lo : acc_lo);
      rem     = neg_a_q ? -acc_hi : acc_hi;
      mac_res = prod_s;
`ifdef HILO_MACC_EN
      if (is_mac_q) mac_res = is_sub_q ? (base_q - prod_s) : (base_q + prod_s);
`endif
      {res_hi, res_lo} = is_div_q ? {rem, quot} : mac_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi_data  <= '0;
         lo_data  <= '0;
         is_div_q <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         opnd     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
`ifdef HILO_MACC_EN
         is_mac_q <= 1'b0;
         is_sub_q <= 1'b0;
         base_q   <= '0;
`endif
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         if (accept) begin
            cnt      <= '0;
            is_div_q <= (op[2:1] == 2'b01);
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
            acc_hi   <= '0;
            acc_lo   <= (op[2:1] == 2'b01) ? mag_a : mag_b;
            opnd     <= (op[2:1] == 2'b01) ? mag_b : mag_a;
`ifdef HILO_MACC_EN
            is_mac_q <= op[2];
            is_sub_q <= op[1];
            base_q   <= {hi_data, lo_data};
`endif
         end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            if (is_div_q) begin
               acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
         end
         // A direct write beats the op result for its own register.
         if (hi_we)                          hi_data <= hi_wdata;
         else if (state == FIN && !cancel)   hi_data <= res_hi;
         if (lo_we)                          lo_data <= lo_wdata;
         else if (state == FIN && !cancel)   lo_data <= res_lo;
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed and random checks of hilo_muldiv (WIDTH=32) with a result scoreboard.
// Exercises the accumulate ops when HILO_MACC_EN is defined, the illegal-op path otherwise.
module tb_hilo_muldiv;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset, start, cancel, hi_we, lo_we;
   logic [2:0]   op;
   logic [W-1:0] src_a, src_b, hi_wdata, lo_wdata;
   logic         busy, done;
   logic [W-1:0] hi_data, lo_data;

   int checks   = 0;
   int failures = 0;
   logic [2*W-1:0] sb[$];

   hilo_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
      .busy(busy), .done(done), .hi_data(hi_data), .lo_data(lo_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {HI,LO} computed with plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input logic [63:0] base);
      logic signed [31:0] sa, sb;
      logic signed [63:0] pa, pb;
      logic [63:0] prod;
      sa = a; sb = b;
      if (o[2:1] == 2'b01) begin
         if (b == 0)                                     return {a, 32'hFFFF_FFFF};
         if (o[0])                                       return {a % b, a / b};
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)   return {32'h0, 32'h8000_0000};
         return {32'(sa % sb), 32'(sa / sb)};
      end
      if (o[0]) prod = {32'h0, a} * {32'h0, b};
      else begin
         pa = 64'(sa); pb = 64'(sb);
         prod = pa * pb;
      end
      if (!o[2]) return prod;
      return o[1] ? base - prod : base + prod;
   endfunction

   // Runs one op to completion; optional strobes fire at the given latency (-1 = never).
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hiwe_at, input int lowe_at, input int pulse_at);
      int lat, busy_n;
      logic [63:0] e;
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      sb.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      lat = 0; busy_n = 0;
      while (!done && lat < 100) begin
         if (busy) busy_n++;
         start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         if (lat == hiwe_at) begin hi_we = 1'b1; hi_wdata = 32'hAA; end
         if (lat == lowe_at) begin lo_we = 1'b1; lo_wdata = 32'h55; end
         if (lat == pulse_at) begin start = 1'b1; op = 3'b011; src_a = 32'd9; src_b = 32'd3; end
         if (lowe_at >= 0 && lat == lowe_at + 1) check({tag, " mtlo_busy"}, 64'(lo_data), 64'h55);
         @(negedge clk);
         lat++;
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'(W + 1));
      check({tag, " busy_cycles"}, 64'(busy_n), 64'(W + 1));
      e = sb.pop_front();
      check({tag, " hi"}, 64'(hi_data), 64'(e[63:32]));
      check({tag, " lo"}, 64'(lo_data), 64'(e[31:0]));
      @(negedge clk);
      check({tag, " done_pulse"}, {62'h0, done, busy}, 64'h0);
   endtask

   // Watches for a stray done over n cycles.
   task automatic quiet(input string tag, input int n);
      int dn = 0;
      repeat (n) begin
         @(negedge clk);
         if (done) dn++;
      end
      check({tag, " no_done"}, 64'(dn), 64'h0);
   endtask

   task automatic direct_write(input logic [31:0] h, input logic [31:0] l);
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; hi_wdata = h; lo_wdata = l;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  ro;
      reset = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 3'b000; src_a = '0; src_b = '0; hi_wdata = '0; lo_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset hi", 64'(hi_data), 64'h0);
      check("reset lo", 64'(lo_data), 64'h0);
      check("reset busy_done", {62'h0, busy, done}, 64'h0);

      run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, -1, -1, -1);
      run_op("divu", 3'b011, 32'd100, 32'd7, {32'd2, 32'd14}, -1, -1, -1);
      run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1, -1, -1);
      run_op("div_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1, -1, -1);
      run_op("div_zero", 3'b010, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF, -1, -1, 5);
      quiet("div_zero", 40);

      // Cancel sampled at edge 10 after accept.
      @(negedge clk);
      start = 1'b1; op = 3'b001; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel busy", 64'(busy), 64'h0);
      quiet("cancel", 40);
      check("cancel hilo", {hi_data, lo_data}, 64'h0000_1234_FFFF_FFFF);

      // Cancel and start together in IDLE: nothing accepted.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = 3'b001; src_a = 32'd2; src_b = 32'd2;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      check("cancel_start busy", 64'(busy), 64'h0);

      run_op("fin_mthi", 3'b001, 32'd3, 32'd4, {32'hAA, 32'd12}, W, -1, -1);

      // Reset sampled at edge 20 after accept.
      @(negedge clk);
      start = 1'b1; op = 3'b001; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset outputs", {hi_data, lo_data}, 64'h0);
      check("midreset busy_done", {62'h0, busy, done}, 64'h0);
      quiet("midreset", 40);

      run_op("mtlo_busy", 3'b001, 32'd3, 32'd4, {32'h0, 32'd12}, -1, 3, -1);

      for (int i = 0; i < 8; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
         if (i % 3 == 0) rb = -rb;
         run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb, 64'h0), -1, -1, -1);
      end

`ifdef HILO_MACC_EN
      direct_write(32'h0, 32'd10);
      run_op("madd", 3'b100, 32'hFFFF_FFFE, 32'd3, {32'h0, 32'd4}, -1, -1, -1);
      direct_write(32'h0, 32'h0);
      run_op("msubu", 3'b111, 32'd1, 32'd5, 64'hFFFF_FFFF_FFFF_FFFB, -1, -1, -1);
      direct_write(32'h1234_5678, 32'h9ABC_DEF0);
      run_op("msub", 3'b110, 32'hFFFF_FF00, 32'd77,
             model(3'b110, 32'hFFFF_FF00, 32'd77, 64'h1234_5678_9ABC_DEF0), -1, -1, -1);
`else
      direct_write(32'h0, 32'd10);
      @(negedge clk);
      start = 1'b1; op = 3'b100; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      check("illegal busy", 64'(busy), 64'h0);
      quiet("illegal", 40);
      check("illegal hilo", {hi_data, lo_data}, {32'h0, 32'd10});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
